// File: rtl/track_pkg.sv
// Shared types and screen constants for the tracking-point selector.
package track_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        READY,
        TRACKING
    } sel_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } point_t;

    localparam logic [9:0] SCREEN_X_MAX = 10'd639;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/marker_hit.sv
// Combinational test: does the current pixel fall inside one point's square marker.
module marker_hit #(
    parameter logic [9:0] MARKER_HALF = 10'd3
) (
    input  logic [9:0] draw_x_i,
    input  logic [9:0] draw_y_i,
    input  logic [9:0] px_i,
    input  logic [9:0] py_i,
    input  logic       valid_i,
    output logic       hit_o
);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]        ax;
    logic [10:0]        ay;

    // 11-bit signed differences keep markers from wrapping across the screen edge.
    assign dx = $signed({1'b0, draw_x_i}) - $signed({1'b0, px_i});
    assign dy = $signed({1'b0, draw_y_i}) - $signed({1'b0, py_i});
    assign ax = dx[10] ? 11'(-dx) : 11'(dx);
    assign ay = dy[10] ? 11'(-dy) : 11'(dy);

    assign hit_o = valid_i && (ax <= {1'b0, MARKER_HALF}) && (ay <= {1'b0, MARKER_HALF});

endmodule

// File: rtl/track_point_sel.sv
// Collects mouse-clicked tracking points once per frame, hands the full set to the
// tracker over req/ack, and draws a square marker at every valid point.
module track_point_sel
    import track_pkg::*;
#(
    parameter int         NUM_POINTS  = 4,
    parameter logic [9:0] X_MAX       = SCREEN_X_MAX,
    parameter logic [9:0] Y_MAX       = SCREEN_Y_MAX,
    parameter logic [9:0] MARKER_HALF = 10'd3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] mousex,
    input  logic [9:0] mousey,
    input  logic [1:0] mouse_btn,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [2:0] rd_idx,
    input  logic       track_ack,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic [3:0] point_count,
    output logic       track_req,
    output logic       tracking,
    output logic       is_marker
);

    localparam logic [3:0] FULL = 4'(NUM_POINTS);

    sel_state_t state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [1:0] prev_btn_q;
    logic       frame_clk_delayed_q;
    logic       frame_tick_q;
    point_t     table_q [NUM_POINTS];

    logic       left_edge;
    logic       right_edge;
    logic       wr_en;
    point_t     wr_pt;
    point_t     rd_pt;
    logic [NUM_POINTS-1:0] hits;

    // During reset the delay register follows frame_clk, so a frame clock already
    // high at release is not mistaken for a new rising edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_delayed_q <= frame_clk;
            frame_tick_q        <= 1'b0;
            prev_btn_q          <= 2'b00;
        end else begin
            frame_clk_delayed_q <= frame_clk;
            frame_tick_q        <= frame_clk & ~frame_clk_delayed_q;
            if (frame_tick_q)
                prev_btn_q <= mouse_btn;
        end
    end

    assign left_edge  = frame_tick_q & mouse_btn[0] & ~prev_btn_q[0];
    assign right_edge = frame_tick_q & mouse_btn[1] & ~prev_btn_q[1];
    assign wr_pt      = '{x: clamp10(mousex, X_MAX), y: clamp10(mousey, Y_MAX)};

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (right_edge) begin
                    count_d = 4'd0;
                end else if (left_edge && count_q < FULL) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 4'd1;
                    if (count_q + 4'd1 == FULL)
                        state_d = READY;
                end
            end
            READY: begin
                if (right_edge) begin
                    state_d = COLLECT;
                    count_d = 4'd0;
                end else if (track_ack) begin
                    state_d = TRACKING;
                end
            end
            TRACKING: begin
                if (right_edge) begin
                    state_d = COLLECT;
                    count_d = 4'd0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= COLLECT;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the point table is small and must read back as zero after reset, so it is
    // built from reset flops rather than a RAM.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (Reset)
                table_q[i] <= '0;
            else if (wr_en && count_q == 4'(i))
                table_q[i] <= wr_pt;
        end
    end

    // Out-of-range indices fall through to zero; invalid slots show stale data.
    always_comb begin
        rd_pt = '0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (rd_idx == 3'(i))
                rd_pt = table_q[i];
        end
    end

    assign rd_x        = rd_pt.x;
    assign rd_y        = rd_pt.y;
    assign point_count = count_q;
    assign track_req   = (state_q == READY);
    assign tracking    = (state_q == TRACKING);

    for (genvar g = 0; g < NUM_POINTS; g++) begin : g_marker
        marker_hit #(
            .MARKER_HALF(MARKER_HALF)
        ) u_hit (
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .px_i     (table_q[g].x),
            .py_i     (table_q[g].y),
            .valid_i  (4'(g) < count_q),
            .hit_o    (hits[g])
        );
    end

    assign is_marker = |hits;

endmodule

// File: tb/tb_track_point_sel.sv
// Directed bench for track_point_sel: collection, handshake, clears, clamp, markers, reset.
module tb_track_point_sel;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [9:0] mousex, mousey;
    logic [1:0] mouse_btn;
    logic [9:0] DrawX, DrawY;
    logic [2:0] rd_idx;
    logic       track_ack;
    logic [9:0] rd_x, rd_y;
    logic [3:0] point_count;
    logic       track_req, tracking, is_marker;

    int n_checks = 0;
    int n_fail   = 0;

    track_point_sel dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .mousex      (mousex),
        .mousey      (mousey),
        .mouse_btn   (mouse_btn),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rd_idx      (rd_idx),
        .track_ack   (track_ack),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .point_count (point_count),
        .track_req   (track_req),
        .tracking    (tracking),
        .is_marker   (is_marker)
    );

    always #10 Clk = ~Clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach the end of its step list");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One frame: inputs held while frame_clk pulses high; outputs settled on return.
    task automatic do_frame(input logic [1:0] btn, input logic [9:0] x, input logic [9:0] y);
        @(negedge Clk);
        mouse_btn = btn;
        mousex    = x;
        mousey    = y;
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic click(input logic [9:0] x, input logic [9:0] y);
        do_frame(2'b01, x, y);
        do_frame(2'b00, x, y);
    endtask

    task automatic right_click();
        do_frame(2'b10, 10'd0, 10'd0);
        do_frame(2'b00, 10'd0, 10'd0);
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        mousex    = '0;
        mousey    = '0;
        mouse_btn = 2'b00;
        DrawX     = 10'd500;
        DrawY     = 10'd300;
        rd_idx    = 3'd0;
        track_ack = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        check("reset_count", point_count, 0);
        check("reset_req", track_req, 0);
        check("reset_tracking", tracking, 0);
        check("reset_rd_x", rd_x, 0);
        check("reset_marker", is_marker, 0);

        click(10'd10, 10'd20);
        check("count_1", point_count, 1);
        click(10'd100, 10'd200);
        check("count_2", point_count, 2);
        click(10'd300, 10'd400);
        check("count_3", point_count, 3);
        check("req_before_full", track_req, 0);
        click(10'd639, 10'd479);
        check("count_4", point_count, 4);
        check("ready_req", track_req, 1);
        check("ready_tracking", tracking, 0);
        rd_idx = 3'd2; #1;
        check("rd2_x", rd_x, 300);
        check("rd2_y", rd_y, 400);
        rd_idx = 3'd5; #1;
        check("rd_oob_x", rd_x, 0);
        check("rd_oob_y", rd_y, 0);

        @(negedge Clk); track_ack = 1'b1;
        @(negedge Clk); track_ack = 1'b0;
        check("ack_req", track_req, 0);
        check("ack_tracking", tracking, 1);
        click(10'd5, 10'd5);
        check("frozen_count", point_count, 4);
        rd_idx = 3'd0; #1;
        check("frozen_x", rd_x, 10);
        check("frozen_y", rd_y, 20);

        right_click();
        check("rclr_count", point_count, 0);
        check("rclr_req", track_req, 0);
        check("rclr_tracking", tracking, 0);
        check("stale_x", rd_x, 10);

        for (int i = 0; i < 5; i++)
            do_frame(2'b01, 10'd77, 10'd88);
        do_frame(2'b00, 10'd77, 10'd88);
        check("held_count", point_count, 1);
        rd_idx = 3'd0; #1;
        check("held_x", rd_x, 77);
        check("held_y", rd_y, 88);
        click(10'd700, 10'd500);
        check("clamp_count", point_count, 2);
        rd_idx = 3'd1; #1;
        check("clamp_x", rd_x, 639);
        check("clamp_y", rd_y, 479);

        do_frame(2'b11, 10'd1, 10'd1);
        do_frame(2'b00, 10'd1, 10'd1);
        check("rl_count", point_count, 0);
        check("rl_req", track_req, 0);
        check("rl_tracking", tracking, 0);
        @(negedge Clk); track_ack = 1'b1;
        @(negedge Clk); track_ack = 1'b0;
        check("ack_ignored", tracking, 0);

        click(10'd50, 10'd50);
        check("mk_count", point_count, 1);
        pixel(10'd47, 10'd53); check("mk_47_53", is_marker, 1);
        pixel(10'd53, 10'd47); check("mk_53_47", is_marker, 1);
        pixel(10'd54, 10'd50); check("mk_54_50", is_marker, 0);
        pixel(10'd50, 10'd46); check("mk_50_46", is_marker, 0);
        pixel(10'd639, 10'd479); check("mk_stale_slot", is_marker, 0);

        right_click();
        click(10'd0, 10'd0);
        pixel(10'd1023, 10'd0); check("mk_nowrap", is_marker, 0);
        pixel(10'd3, 10'd3); check("mk_origin", is_marker, 1);

        click(10'd1, 10'd1);
        click(10'd2, 10'd2);
        click(10'd3, 10'd3);
        check("refill_req", track_req, 1);
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b1;
        mouse_btn = 2'b01;
        mousex    = 10'd9;
        mousey    = 10'd9;
        @(negedge Clk);
        check("rst_count", point_count, 0);
        check("rst_req", track_req, 0);
        check("rst_tracking", tracking, 0);
        rd_idx = 3'd0; #1;
        check("rst_table", rd_x, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        check("no_tick_after_rst", point_count, 0);
        frame_clk = 1'b0;
        mouse_btn = 2'b00;
        repeat (3) @(negedge Clk);
        check("no_tick_final", point_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
